seg7_scan_decoder: RTL

//  Receive-side counterpart of the BCD-to-7-segment display path. Snoops a multiplexed
//  (scanned) display bus (digit select + segment lines) and reconstructs the digit value

---
 rtl/seg7_scan_decoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Reads back a scanned 7-segment display bus and reconstructs the committed BCD digit per position.
// Optional macro SEG7_HEX_EN also decodes the A..F glyphs as hex numerals.
module seg7_scan_decoder #(
  parameter int DIGITS     = 8,
  parameter int STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     iAn,
  input  logic [6:0]            iSeg,
  output logic [4*DIGITS-1:0]   oDigits,
  output logic [DIGITS-1:0]     oValid,
  output logic [DIGITS-1:0]     oErr,
  output logic                  oUpdate
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] STABLE = 4'(STABLE_CNT);

  logic [DIGITS-1:0]   anReg;
  logic [6:0]          segReg;
  logic [6:0]          lastPat [DIGITS];
  logic [3:0]          cnt     [DIGITS];

  logic [3:0]          lowCnt;
  logic [IDX_W-1:0]    selIdx;
  logic                sampleOk;
  logic [3:0]          cntNext;
  logic                commit;
  logic [5:0]          decoded;
  logic [4*DIGITS-1:0] digitsNext;
  logic [DIGITS-1:0]   validNext;
  logic [DIGITS-1:0]   errNext;
  logic                changed;

  // Result is {valid, err, nibble}; anything unrecognised flags an error and leaves the nibble alone.
  function automatic logic [5:0] decodeSeg(input logic [6:0] pat);
    logic [5:0] res;
    res = 6'b01_0000;
    case (pat)
      7'b1000000: res = 6'b10_0000;
      7'b1111001: res = 6'b10_0001;
      7'b0100100: res = 6'b10_0010;
      7'b0110000: res = 6'b10_0011;
      7'b0011001: res = 6'b10_0100;
      7'b0010010: res = 6'b10_0101;
      7'b0000010: res = 6'b10_0110;
      7'b1111000: res = 6'b10_0111;
      7'b0000000: res = 6'b10_1000;
      7'b0010000: res = 6'b10_1001;
`ifdef SEG7_HEX_EN
      7'b0001000: res = 6'b10_1010;
      7'b0000011: res = 6'b10_1011;
      7'b1000110: res = 6'b10_1100;
      7'b0100001: res = 6'b10_1101;
      7'b0000110: res = 6'b10_1110;
      7'b0001110: res = 6'b10_1111;
`endif
      7'b1111111: res = 6'b00_0000;
      default:    res = 6'b01_0000;
    endcase
    return res;
  endfunction

  // A sample only counts when exactly one digit select is low.
  always_comb begin
    lowCnt = 4'd0;
    selIdx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!anReg[i]) begin
        lowCnt = lowCnt + 4'd1;
        selIdx = IDX_W'(i);
      end
    end
    sampleOk = (lowCnt == 4'd1);
  end

  always_comb begin
    cntNext    = 4'd1;
    commit     = 1'b0;
    decoded    = decodeSeg(segReg);
    digitsNext = oDigits;
    validNext  = oValid;
    errNext    = oErr;
    if (sampleOk) begin
      if (segReg == lastPat[selIdx]) begin
        cntNext = (cnt[selIdx] < STABLE) ? cnt[selIdx] + 4'd1 : cnt[selIdx];
      end
      commit = (cntNext == STABLE);
    end
    if (commit) begin
      validNext[selIdx] = decoded[5];
      errNext[selIdx]   = decoded[4];
      if (decoded[5]) begin
        digitsNext[int'(selIdx)*4 +: 4] = decoded[3:0];
      end
    end
    changed = (digitsNext != oDigits) || (validNext != oValid) || (errNext != oErr);
  end

  // Commit lands on the same edge that brings the counter to the threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      anReg   <= '1;
      segReg  <= 7'h7F;
      oDigits <= '0;
      oValid  <= '0;
      oErr    <= '0;
      oUpdate <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        lastPat[i] <= 7'h7F;
        cnt[i]     <= 4'd0;
      end
    end else begin
      anReg   <= iAn;
      segReg  <= iSeg;
      oDigits <= digitsNext;
      oValid  <= validNext;
      oErr    <= errNext;
      oUpdate <= changed;
      if (sampleOk) begin
        lastPat[selIdx] <= segReg;
        cnt[selIdx]     <= cntNext;
      end
    end
  end

endmodule
